// File: rtl/fifo_sync.sv
// Synchronous first-word-fall-through FIFO with registered full/empty flags.
// Define FIFO_STATUS_EN to add level/overflow/underflow status outputs.
module fifo_sync #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  full,
    output logic                  empty
`ifdef FIFO_STATUS_EN
    ,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] w_ptr, r_ptr;
    logic [ADDR_WIDTH-1:0] w_ptr_inc, r_ptr_inc;
    logic                  push, pop;

    // A full FIFO still takes a push when a pop frees the head slot in the same cycle.
    assign push      = wr & (~full | rd);
    assign pop       = rd & ~empty;
    assign w_ptr_inc = w_ptr + ADDR_WIDTH'(1);
    assign r_ptr_inc = r_ptr + ADDR_WIDTH'(1);
    assign r_data    = mem[r_ptr];

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push)
            mem[w_ptr] <= w_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr <= '0;
            r_ptr <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (push)
                w_ptr <= w_ptr_inc;
            if (pop)
                r_ptr <= r_ptr_inc;
            case ({push, pop})
                2'b10: begin
                    empty <= 1'b0;
                    full  <= (w_ptr_inc == r_ptr);
                end
                2'b01: begin
                    full  <= 1'b0;
                    empty <= (r_ptr_inc == w_ptr);
                end
                default: ;
            endcase
        end
    end

`ifdef FIFO_STATUS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10:   level <= level + (ADDR_WIDTH + 1)'(1);
                2'b01:   level <= level - (ADDR_WIDTH + 1)'(1);
                default: ;
            endcase
            if (wr && !push)
                overflow <= 1'b1;
            if (rd && empty)
                underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// Scoreboard bench for fifo_sync: the driver queues expected words, a negedge
// monitor checks flags, head word and pops against the queue.
module tb_fifo_sync;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic [DW-1:0] w_data = '0;
    logic [DW-1:0] r_data;
    logic          full, empty;
`ifdef FIFO_STATUS_EN
    logic [AW:0]   level;
    logic          overflow, underflow;
`endif

    fifo_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .wr(wr), .w_data(w_data), .rd(rd),
        .r_data(r_data), .full(full), .empty(empty)
`ifdef FIFO_STATUS_EN
        , .level(level), .overflow(overflow), .underflow(underflow)
`endif
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];
    int            mcnt = 0;
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides acceptance from its own count.
    task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r);
        bit push_ok, pop_ok;
        wr = w; w_data = d; rd = r;
        pop_ok  = r && (mcnt > 0);
        push_ok = w && ((mcnt < DEPTH) || r);
        if (push_ok)
            exp_q.push_back(d);
        @(posedge clk);
        if (w && !r && mcnt == DEPTH) m_ovf = 1'b1;
        if (r && mcnt == 0)           m_unf = 1'b1;
        mcnt = mcnt + int'(push_ok) - int'(pop_ok);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("full", full, 32'(mcnt == DEPTH));
            chk("empty", empty, 32'(mcnt == 0));
`ifdef FIFO_STATUS_EN
            chk("level", level, mcnt);
            chk("overflow", overflow, m_ovf);
            chk("underflow", underflow, m_unf);
`endif
            if (mcnt > 0) begin
                chk("head", r_data, exp_q[0]);
                if (rd)
                    void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #12;
        chk("reset_empty", empty, 1);
        chk("reset_full", full, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(0, 8'h00, 0);
        cycle(0, 8'h00, 0);

        // fill, drop on full, simultaneous push/pop on full, drain
        cycle(1, 8'h11, 0);
        cycle(1, 8'h22, 0);
        cycle(1, 8'h33, 0);
        cycle(1, 8'h44, 0);
        cycle(1, 8'h55, 0);
        cycle(1, 8'h55, 1);
        for (int i = 0; i < 4; i++)
            cycle(0, 8'h00, 1);

        // pops while empty, then a single push must appear at the head
        for (int i = 0; i < 3; i++)
            cycle(0, 8'h00, 1);
        cycle(1, 8'hA5, 0);
        cycle(0, 8'h00, 0);
        cycle(0, 8'h00, 1);

        // push+pop on empty: only the push is taken
        cycle(1, 8'h5A, 1);
        cycle(0, 8'h00, 1);

        // interleaved traffic wrapping both pointers
        for (int r = 0; r < 2; r++) begin
            cycle(1, 8'h60 + 8'(r * 16), 0);
            cycle(1, 8'h61 + 8'(r * 16), 0);
            for (int i = 2; i < 6; i++)
                cycle(1, 8'h60 + 8'(r * 16 + i), 1);
            cycle(0, 8'h00, 1);
            cycle(0, 8'h00, 1);
        end
        chk("drained", exp_q.size(), 0);

        // asynchronous reset with two words queued
        cycle(1, 8'h71, 0);
        cycle(1, 8'h72, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_empty", empty, 1);
        chk("async_full", full, 0);
`ifdef FIFO_STATUS_EN
        chk("async_level", level, 0);
        chk("async_underflow", underflow, 0);
`endif
        exp_q.delete();
        mcnt  = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        wr = 1'b1; rd = 1'b1; w_data = 8'hEE;
        @(posedge clk);
        #1;
        chk("reset_hold_empty", empty, 1);
        #2 rst_n = 1'b1;
        wr = 1'b0; rd = 1'b0;
        @(posedge clk);
        #1;
        cycle(1, 8'h99, 0);
        cycle(0, 8'h00, 1);
        cycle(0, 8'h00, 0);
        chk("final_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
